// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC, status and retirement controller for the single-cycle Y86-64 core
//
// Purpose: holds the architectural PC, selects the next PC from fetch/execute/memory
// results, tracks the Y86 status (AOK/HLT/ADR/INS), gates commits with run, single-step
// and stall controls, and keeps saturating cycle and retire counters.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   run_i, step_i       free-run enable and single-step request (rising edge only)
//   stall_i             hold all architectural state this cycle
//   icode_i             instruction code from fetch
//   instr_valid_i       fetch reports a legal icode
//   imem_error_i        fetch PC out of instruction memory range
//   dmem_error_i        data memory address error for the current instruction
//   cnd_i               branch condition from execute
//   valc_i, valp_i      constant word and fall-through PC from fetch
//   valm_i              data memory read value (return address for RET)
//   pc_o                current PC, drives fetch
//   stat_o              1=AOK, 2=HLT, 3=ADR, 4=INS
//   retire_o            one-cycle pulse the cycle after an instruction retires
//   retire_pc_o         PC of the instruction flagged by retire_o
//   cycle_cnt_o         cycles spent in AOK (saturating)
//   retire_cnt_o        instructions retired (saturating)

module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             stall_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             dmem_error_i,
  input  logic             cnd_i,
  input  logic [63:0]      valc_i,
  input  logic [63:0]      valp_i,
  input  logic [63:0]      valm_i,
  output logic [63:0]      pc_o,
  output logic [2:0]       stat_o,
  output logic             retire_o,
  output logic [63:0]      retire_pc_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    ST_AOK = 3'd1,
    ST_HLT = 3'd2,
    ST_ADR = 3'd3,
    ST_INS = 3'd4
  } stat_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stat_e            stat_q, stat_d;
  logic [63:0]      pc_q, pc_d;
  logic             step_q;
  logic             retire_q, retire_d;
  logic [63:0]      retire_pc_q, retire_pc_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic step_rise;
  logic advance;
  logic retire_now;
  logic dmem_user;

  assign step_rise = step_i & ~step_q;
  // run and a step edge in the same cycle still commit only once.
  assign advance   = (stat_q == ST_AOK) & ~stall_i & (run_i | step_rise);

  // Only loads, stores, push/pop and call/ret touch data memory.
  always_comb begin
    dmem_user = 1'b0;
    case (icode_i)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: dmem_user = 1'b1;
      default:                           dmem_user = 1'b0;
    endcase
  end

  always_comb begin
    stat_d       = stat_q;
    pc_d         = pc_q;
    retire_now   = 1'b0;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    retire_d     = 1'b0;
    retire_pc_d  = retire_pc_q;

    case (stat_q)
      ST_AOK: begin
        // Counted even for the cycle that halts or faults.
        if (cycle_cnt_q != CNT_MAX) begin
          cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end
        if (advance) begin
          if (imem_error_i) begin
            stat_d = ST_ADR;
          end else if (!instr_valid_i) begin
            stat_d = ST_INS;
          end else if (icode_i == 4'h0) begin
            stat_d     = ST_HLT;
            retire_now = 1'b1;
          end else if (dmem_error_i && dmem_user) begin
            stat_d = ST_ADR;
          end else begin
            retire_now = 1'b1;
            case (icode_i)
              4'h7:    pc_d = cnd_i ? valc_i : valp_i;
              4'h8:    pc_d = valc_i;
              4'h9:    pc_d = valm_i;
              default: pc_d = valp_i;
            endcase
          end
        end
      end
      default: begin
        // Terminal states are sticky until reset; everything holds.
      end
    endcase

    if (retire_now) begin
      retire_d    = 1'b1;
      retire_pc_d = pc_q;
      if (retire_cnt_q != CNT_MAX) begin
        retire_cnt_d = retire_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_q       <= ST_AOK;
      pc_q         <= RESET_PC;
      step_q       <= 1'b0;
      retire_q     <= 1'b0;
      retire_pc_q  <= 64'd0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stat_q       <= stat_d;
      pc_q         <= pc_d;
      // Tracked even while stalled, so an edge seen only during a stall is lost.
      step_q       <= step_i;
      retire_q     <= retire_d;
      retire_pc_q  <= retire_pc_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign pc_o         = pc_q;
  assign stat_o       = stat_q;
  assign retire_o     = retire_q;
  assign retire_pc_o  = retire_pc_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
//
// Purpose: drives directed and random stimulus into two pc_sequencer instances
// (CNT_W=32 and CNT_W=4) that share all inputs, and checks every cycle against
// a behavioural model through an expectation queue.
// Ports: none (top-level bench).

module tb_pc_sequencer;

  typedef struct {
    logic        rst;
    logic        run;
    logic        step;
    logic        stall;
    logic [3:0]  icode;
    logic        iv;
    logic        imem;
    logic        dmem;
    logic        cnd;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] valm;
  } stim_t;

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        ret_v;
    logic        chk_rpc;
    logic [63:0] rpc;
    longint      cyc;
    longint      rcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, run = 1'b0, step = 1'b0, stall = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        iv = 1'b1, imem = 1'b0, dmem = 1'b0, cnd = 1'b0;
  logic [63:0] valc = '0, valp = '0, valm = '0;

  logic [63:0] pc, rpc, pc4, rpc4;
  logic [2:0]  stat, stat4;
  logic        retire, retire4;
  logic [31:0] cyc, rcnt;
  logic [3:0]  cyc4, rcnt4;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Behavioural model state
  logic [63:0] m_pc = '0;
  logic [63:0] m_rpc = '0;
  int          m_stat = 1;
  logic        m_stepq = 1'b0;
  longint      m_cyc = 0;
  longint      m_rcnt = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(64'd0), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step), .stall_i(stall),
    .icode_i(icode), .instr_valid_i(iv), .imem_error_i(imem), .dmem_error_i(dmem),
    .cnd_i(cnd), .valc_i(valc), .valp_i(valp), .valm_i(valm),
    .pc_o(pc), .stat_o(stat), .retire_o(retire), .retire_pc_o(rpc),
    .cycle_cnt_o(cyc), .retire_cnt_o(rcnt)
  );

  pc_sequencer #(.RESET_PC(64'd0), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step), .stall_i(stall),
    .icode_i(icode), .instr_valid_i(iv), .imem_error_i(imem), .dmem_error_i(dmem),
    .cnd_i(cnd), .valc_i(valc), .valp_i(valp), .valm_i(valm),
    .pc_o(pc4), .stat_o(stat4), .retire_o(retire4), .retire_pc_o(rpc4),
    .cycle_cnt_o(cyc4), .retire_cnt_o(rcnt4)
  );

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t base();
    stim_t s;
    s.rst = 1'b0; s.run = 1'b0; s.step = 1'b0; s.stall = 1'b0;
    s.icode = 4'h1; s.iv = 1'b1; s.imem = 1'b0; s.dmem = 1'b0; s.cnd = 1'b0;
    s.valc = '0; s.valp = m_pc + 64'd10; s.valm = '0;
    return s;
  endfunction

  // Apply one cycle of stimulus and record what the next clock edge must produce.
  task automatic drive(input stim_t s);
    exp_t        e;
    logic        rise;
    logic        did;
    logic [63:0] old_pc;
    @(negedge clk);
    rst = s.rst; run = s.run; step = s.step; stall = s.stall; icode = s.icode;
    iv = s.iv; imem = s.imem; dmem = s.dmem; cnd = s.cnd;
    valc = s.valc; valp = s.valp; valm = s.valm;
    did = 1'b0;
    if (s.rst) begin
      m_pc = '0; m_stat = 1; m_rpc = '0; m_cyc = 0; m_rcnt = 0; m_stepq = 1'b0;
      e.chk_rpc = 1'b1;
    end else begin
      rise = s.step && !m_stepq;
      m_stepq = s.step;
      old_pc = m_pc;
      if (m_stat == 1) begin
        m_cyc++;
        if (!s.stall && (s.run || rise)) begin
          if (s.imem) m_stat = 3;
          else if (!s.iv) m_stat = 4;
          else if (s.icode == 4'h0) begin
            m_stat = 2;
            did = 1'b1;
          end else if (s.dmem && (s.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})) m_stat = 3;
          else begin
            did = 1'b1;
            if ((s.icode == 4'h7 && s.cnd) || s.icode == 4'h8) m_pc = s.valc;
            else if (s.icode == 4'h9) m_pc = s.valm;
            else m_pc = s.valp;
          end
        end
      end
      if (did) begin
        m_rpc = old_pc;
        m_rcnt++;
      end
      e.chk_rpc = did;
    end
    e.pc = m_pc; e.stat = 3'(m_stat); e.ret_v = did; e.rpc = m_rpc;
    e.cyc = m_cyc; e.rcnt = m_rcnt;
    exp_q.push_back(e);
  endtask

  // Idle cycle, after which outputs reflect all earlier stimulus.
  task automatic settle();
    drive(base());
  endtask

  // Monitor: pops one expectation per clock and compares both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("stat", 64'(stat), 64'(e.stat));
        check("retire", 64'(retire), 64'(e.ret_v));
        if (e.chk_rpc) check("retire_pc", rpc, e.rpc);
        check("cycle_cnt", 64'(cyc), 64'(sat(e.cyc, 32)));
        check("retire_cnt", 64'(rcnt), 64'(sat(e.rcnt, 32)));
        check("pc_w4", pc4, e.pc);
        check("stat_w4", 64'(stat4), 64'(e.stat));
        check("retire_w4", 64'(retire4), 64'(e.ret_v));
        check("cycle_cnt_w4", 64'(cyc4), 64'(sat(e.cyc, 4)));
        check("retire_cnt_w4", 64'(rcnt4), 64'(sat(e.rcnt, 4)));
      end
    end
  end

  initial begin
    stim_t  s;
    longint c0;

    // Reset state
    s = base(); s.rst = 1'b1;
    drive(s); drive(s);

    // Preloaded program: 0 -> 10 -> 20, halt at 20
    for (int i = 0; i < 6; i++) begin
      s = base(); s.run = 1'b1;
      s.icode = (m_pc == 64'd20) ? 4'h0 : ((m_pc == 64'd0) ? 4'h6 : 4'h2);
      drive(s);
    end
    settle();
    check("prog_pc", pc, 64'd20);
    check("prog_stat", 64'(stat), 64'd2);
    check("prog_retire_cnt", 64'(rcnt), 64'd3);

    // Reset while halted, then single-step with step held high
    s = base(); s.rst = 1'b1; drive(s);
    settle();
    check("rst_hlt_pc", pc, 64'd0);
    check("rst_hlt_stat", 64'(stat), 64'd1);
    for (int i = 0; i < 5; i++) begin
      s = base(); s.step = 1'b1; s.icode = 4'h6; drive(s);
    end
    settle();
    check("step_once_pc", pc, 64'd10);
    s = base(); s.step = 1'b1; s.icode = 4'h6; drive(s);
    settle();
    check("step_twice_pc", pc, 64'd20);

    // Control flow
    s = base(); s.rst = 1'b1; drive(s);
    s = base(); s.run = 1'b1; s.icode = 4'h8; s.valc = 64'd52; drive(s);
    s = base(); s.run = 1'b1; s.icode = 4'h7; s.cnd = 1'b1; s.valc = 64'h47; s.valp = 64'd61; drive(s);
    settle();
    check("jxx_taken_pc", pc, 64'h47);
    s = base(); s.run = 1'b1; s.icode = 4'h8; s.valc = 64'd52; drive(s);
    s = base(); s.run = 1'b1; s.icode = 4'h7; s.cnd = 1'b0; s.valc = 64'h47; s.valp = 64'd61; drive(s);
    settle();
    check("jxx_not_taken_pc", pc, 64'd61);
    s = base(); s.run = 1'b1; s.icode = 4'h8; s.valc = 64'd1; drive(s);
    s = base(); s.run = 1'b1; s.icode = 4'h9; s.valm = 64'h3D; drive(s);
    settle();
    check("ret_pc", pc, 64'h3D);
    s = base(); s.run = 1'b1; s.icode = 4'h2; s.dmem = 1'b1; drive(s);
    settle();
    check("dmem_ignored_stat", 64'(stat), 64'd1);

    // Faults
    s = base(); s.run = 1'b1; s.icode = 4'hC; s.iv = 1'b0; drive(s);
    settle();
    check("ins_stat", 64'(stat), 64'd4);
    s = base(); s.rst = 1'b1; drive(s);
    s = base(); s.run = 1'b1; s.icode = 4'h5; s.dmem = 1'b1; drive(s);
    settle();
    check("dmem_adr_stat", 64'(stat), 64'd3);
    s = base(); s.rst = 1'b1; drive(s);
    s = base(); s.run = 1'b1; s.imem = 1'b1; s.iv = 1'b0; drive(s);
    settle();
    check("imem_wins_stat", 64'(stat), 64'd3);

    // Stall at pc 10, then a step edge lost inside a stall
    s = base(); s.rst = 1'b1; drive(s);
    s = base(); s.run = 1'b1; s.icode = 4'h6; drive(s);
    c0 = m_cyc;
    for (int i = 0; i < 3; i++) begin
      s = base(); s.run = 1'b1; s.stall = 1'b1; s.icode = 4'h6; drive(s);
    end
    check("stall_cycles", 64'(m_cyc - c0), 64'd3);
    settle();
    check("stall_pc", pc, 64'd10);
    s = base(); s.run = 1'b1; s.icode = 4'h6; drive(s);
    settle();
    check("post_stall_pc", pc, 64'd20);
    s = base(); s.stall = 1'b1; s.step = 1'b1; drive(s);
    s = base(); s.step = 1'b1; drive(s);
    settle();
    check("lost_step_pc", pc, 64'd20);

    // Reset during a stall
    s = base(); s.rst = 1'b1; s.stall = 1'b1; s.run = 1'b1; drive(s);
    settle();
    check("rst_stall_pc", pc, 64'd0);

    // Saturation of the 4-bit counters
    for (int i = 0; i < 20; i++) settle();
    check("cyc_w4_sat", 64'(cyc4), 64'd15);

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      s = base();
      s.rst   = ((m_stat != 1) && ($urandom_range(3) == 0)) || ($urandom_range(99) == 0);
      s.run   = $urandom_range(1) == 1;
      s.step  = $urandom_range(1) == 1;
      s.stall = $urandom_range(5) == 0;
      s.icode = 4'($urandom_range(15));
      s.iv    = $urandom_range(19) != 0;
      s.imem  = $urandom_range(39) == 0;
      s.dmem  = $urandom_range(7) == 0;
      s.cnd   = $urandom_range(1) == 1;
      s.valc  = {$urandom, $urandom};
      s.valp  = {$urandom, $urandom};
      s.valm  = {$urandom, $urandom};
      drive(s);
    end

    settle();
    settle();
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequential controller for the single-cycle Y86-64 core.
- Owns the architectural PC register that drives the fetch stage's pc_i, and selects the next PC from fetch, execute and memory results.
- Tracks the Y86 processor status (AOK/HLT/ADR/INS) and gates retirement with run, single-step and stall controls.
- Keeps cycle and retired-instruction counters for the testbench and debug.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
CNT_W, 32, width of cycle and retire counters

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
run_i  input  1  free-run enable: one instruction retires per cycle while high
step_i  input  1  single-step request; only its rising edge counts
stall_i  input  1  holds all architectural state this cycle
icode_i  input  4  instruction code from fetch
instr_valid_i  input  1  fetch says icode is legal
imem_error_i  input  1  fetch PC out of instruction memory range
dmem_error_i  input  1  data memory address error for the current instruction
cnd_i  input  1  branch condition from execute
valc_i  input  64  constant word from fetch
valp_i  input  64  fall-through PC from fetch
valm_i  input  64  value read from data memory (return address for RET)
pc_o  output  64  current PC, drives fetch pc_i
stat_o  output  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS
retire_o  output  1  registered one-cycle pulse after each retired instruction
retire_pc_o  output  64  PC of the instruction flagged by retire_o
cycle_cnt_o  output  CNT_W  cycles spent in AOK
retire_cnt_o  output  CNT_W  instructions retired

Behaviour:
Reset values (rst_i sampled high at a clock edge):
- pc_o=RESET_PC, stat_o=AOK, retire_o=0, retire_pc_o=0, both counters=0, step edge-detect register=0.
- Reset overrides every other input, including mid-stall or while in a terminal state.

States: AOK (running/ready), plus terminal states HLT, ADR, INS.
- Terminal states are sticky until reset.
- In a terminal state pc_o holds and the counters freeze.

Commit enable:
- step_rise = step_i & ~step_q; step_q <= step_i every cycle, including during stall.
- advance = (stat==AOK) & ~stall_i & (run_i | step_rise).
- run_i and step_rise together yield exactly one commit.
- A step edge that arrives during a stall is lost.

On advance, the first matching rule applies:
1. imem_error_i -> stat=ADR, PC holds, no retire.
2. ~instr_valid_i -> stat=INS, PC holds, no retire.
3. icode==0 (halt) -> stat=HLT, PC holds, retire counted.
4. dmem_error_i and icode in {4,5,8,9,A,B} -> stat=ADR, PC holds, no retire. dmem_error_i is ignored for every other icode.
5. Otherwise retire. Next PC:
   - icode 7 with cnd_i=1 -> valc_i
   - icode 8 -> valc_i
   - icode 9 -> valm_i
   - all other icodes -> valp_i
   - 64-bit assignment, no range check; wrap-around is the fetch stage's concern via imem_error_i.

Retire side effects:
- On any retire, the next cycle has retire_o=1 and retire_pc_o=PC of the retired instruction; retire_cnt increments.
- retire_o=0 in every cycle with no retire.

Counters:
- cycle_cnt increments every cycle stat==AOK, stalled or idle included; it also counts the faulting or halting cycle.
- Both counters saturate at all-ones; they never wrap.

Stall: stall_i=1 holds pc_o, stat_o and retire_cnt, and forces retire_o low next cycle.

Idle: with run_i=0 and no step edge, all state holds and only cycle_cnt advances.

Test Plan:
- Reset, then run_i=1 over the preloaded program: pc_o goes 0 -> 10 (0x0A) -> 20 (0x14). At 20, icode 0: stat_o=2 next cycle, pc_o stays 20, retire_cnt=3, and all state stays frozen afterwards.
- Step mode, run_i=0, step_i held high for 5 cycles: exactly one commit (pc 0 -> 10) and one retire_o pulse with retire_pc_o=0. A second rising edge gives pc=20.
- Control flow:
  - icode 7 at pc 52, cnd_i=1, valc_i=0x47: next pc 0x47.
  - Same with cnd_i=0, valp_i=61: next pc 61.
  - icode 8 with valc_i=1: next pc 1.
  - icode 9 with valm_i=0x3D: next pc 0x3D.
- Faults:
  - icode 0xC with instr_valid_i=0: stat=4, pc holds, no retire.
  - Separate run with icode 5 and dmem_error_i=1: stat=3.
  - Separate run with imem_error_i=1 and instr_valid_i=0 together: stat=3, ADR wins.
- stall_i=1 for 3 cycles while running at pc 10: pc holds and no retire_o, while cycle_cnt advances by 3. After release the next commit proceeds normally.
- rst_i asserted in HLT state, and separately during a stall: the next cycle has pc=RESET_PC, stat=1 and counters 0. With CNT_W=4, 20 AOK cycles leave cycle_cnt at 15 (saturated).
